// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that shares one stb/ack floating-point adder among N_REQ requesters.
// Define FP_ADDER_ARBITER_GRANT_COUNT_EN to add saturating per-requester grant counters.
module fp_adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]            req_stb,
    output logic [N_REQ-1:0]            req_ack,
    output logic [WIDTH-1:0]            resp_z,
    output logic [N_REQ-1:0]            resp_stb,
    input  logic [N_REQ-1:0]            resp_ack,
    output logic [WIDTH-1:0]            adder_a,
    output logic                        adder_a_stb,
    input  logic                        adder_a_ack,
    output logic [WIDTH-1:0]            adder_b,
    output logic                        adder_b_stb,
    input  logic                        adder_b_ack,
    input  logic [WIDTH-1:0]            adder_z,
    input  logic                        adder_z_stb,
    output logic                        adder_z_ack
`ifdef FP_ADDER_ARBITER_GRANT_COUNT_EN
    ,
    output logic [N_REQ-1:0][15:0]      grant_count
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESPOND} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr, ptr_nxt, grant, grant_nxt, g_sel;
    logic [N_REQ-1:0]   req_ack_nxt, resp_stb_nxt;
    logic [WIDTH-1:0]   resp_z_nxt, adder_a_nxt, adder_b_nxt;
    logic               adder_a_stb_nxt, adder_b_stb_nxt, adder_z_ack_nxt;

    // Lowest offset from base wins, so scanning downward leaves the nearest hit.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base,
                                              input logic [N_REQ-1:0] mask);
        logic [IW-1:0] sel;
        int            idx;
        sel = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (mask[idx]) sel = IW'(idx);
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_nxt       = grant;
        req_ack_nxt     = '0;
        resp_stb_nxt    = resp_stb;
        resp_z_nxt      = resp_z;
        adder_a_nxt     = adder_a;
        adder_b_nxt     = adder_b;
        adder_a_stb_nxt = adder_a_stb;
        adder_b_stb_nxt = adder_b_stb;
        adder_z_ack_nxt = adder_z_ack;
        g_sel           = rr_pick(ptr, req_stb);
        case (state)
            IDLE: begin
                if (|req_stb) begin
                    grant_nxt          = g_sel;
                    adder_a_nxt        = req_a[g_sel];
                    adder_b_nxt        = req_b[g_sel];
                    req_ack_nxt[g_sel] = 1'b1;
                    adder_a_stb_nxt    = 1'b1;
                    state_nxt          = SEND_A;
                end
            end
            SEND_A: begin
                if (adder_a_ack) begin
                    adder_a_stb_nxt = 1'b0;
                    adder_b_stb_nxt = 1'b1;
                    state_nxt       = SEND_B;
                end
            end
            SEND_B: begin
                if (adder_b_ack) begin
                    adder_b_stb_nxt = 1'b0;
                    adder_z_ack_nxt = 1'b1;
                    state_nxt       = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (adder_z_stb && adder_z_ack) begin
                    resp_z_nxt          = adder_z;
                    adder_z_ack_nxt     = 1'b0;
                    resp_stb_nxt        = '0;
                    resp_stb_nxt[grant] = 1'b1;
                    state_nxt           = RESPOND;
                end
            end
            RESPOND: begin
                // Only the granted requester's ack can release the result.
                if (resp_ack[grant]) begin
                    resp_stb_nxt = '0;
                    ptr_nxt      = next_ptr(grant);
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            req_ack     <= '0;
            resp_stb    <= '0;
            resp_z      <= '0;
            adder_a     <= '0;
            adder_b     <= '0;
            adder_a_stb <= 1'b0;
            adder_b_stb <= 1'b0;
            adder_z_ack <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            req_ack     <= req_ack_nxt;
            resp_stb    <= resp_stb_nxt;
            resp_z      <= resp_z_nxt;
            adder_a     <= adder_a_nxt;
            adder_b     <= adder_b_nxt;
            adder_a_stb <= adder_a_stb_nxt;
            adder_b_stb <= adder_b_stb_nxt;
            adder_z_ack <= adder_z_ack_nxt;
        end
    end

`ifdef FP_ADDER_ARBITER_GRANT_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else begin
            for (int g = 0; g < N_REQ; g++) begin
                if (req_ack[g] && grant_count[g] != 16'hFFFF)
                    grant_count[g] <= grant_count[g] + 16'd1;
            end
        end
    end
`endif

endmodule
